// File: rtl/reorder_buffer_pkg.sv
// Shared ROB/rename constants: sequence-number and tag widths, and the 23-bit commit bundle layout.
package reorder_buffer_pkg;

    localparam int unsigned SQN_W = 7;
    localparam int unsigned NM_W  = 5;
    localparam int unsigned TAG_W = 7;

    // Commit bundle: [22:18] nmDst, [17:11] tagDst, [10:4] sqN, [3] isStore, [2] isLoad, [1] avail, [0] valid
    localparam int unsigned COM_W         = 23;
    localparam int unsigned COM_VALID_BIT = 0;
    localparam int unsigned COM_AVAIL_BIT = 1;
    localparam int unsigned COM_LOAD_BIT  = 2;
    localparam int unsigned COM_STORE_BIT = 3;
    localparam int unsigned COM_SQN_LSB   = 4;
    localparam int unsigned COM_TAG_LSB   = 11;
    localparam int unsigned COM_NM_LSB    = 18;

    typedef struct packed {
        logic             valid;
        logic             done;
        logic [SQN_W-1:0] sqn;
        logic [TAG_W-1:0] tag_dst;
        logic [NM_W-1:0]  nm_dst;
        logic             avail;
        logic             is_load;
        logic             is_store;
    } rob_entry_t;

    // True when a is strictly younger than b in the modulo-128 sequence space.
    function automatic logic sqn_younger(input logic [SQN_W-1:0] a, input logic [SQN_W-1:0] b);
        logic [SQN_W-1:0] diff;
        diff = a - b;
        return (diff != '0) && !diff[SQN_W-1];
    endfunction

endpackage

// File: rtl/reorder_buffer_commit_select.sv
// In-order commit selection over the head window: contiguous valid+done prefix, gated by a mispredict.
module rob_commit_select
    import reorder_buffer_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic [WIDTH-1:0]            i_valid,
    input  logic [WIDTH-1:0]            i_done,
    input  logic [WIDTH-1:0][SQN_W-1:0] i_sqn,
    input  logic                        i_branch_taken,
    input  logic [SQN_W-1:0]            i_branch_sqn,
    output logic [WIDTH-1:0]            o_mask_c,
    output logic [CNT_W-1:0]            o_count_c
);

    logic w_run;
    logic w_ok;

    // Scan stops at the first slot that is not ready or is younger than the branch.
    always_comb begin
        o_mask_c  = '0;
        o_count_c = '0;
        w_run     = 1'b1;
        w_ok      = 1'b0;
        for (int s = 0; s < int'(WIDTH); s++) begin
            w_ok = i_valid[s] && i_done[s] &&
                   !(i_branch_taken && sqn_younger(i_sqn[s], i_branch_sqn));
            w_run       = w_run && w_ok;
            o_mask_c[s] = w_run;
            if (w_run) begin
                o_count_c = o_count_c + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// Reorder buffer: sqN-indexed entry storage, writeback completion, in-order retirement and
// mispredict squash; emits registered commit bundles and the sqN window for back-pressure.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int unsigned LENGTH     = 64,
    parameter int unsigned WIDTH_UOPS = 4,
    parameter int unsigned WIDTH_WR   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH_UOPS-1:0]         IN_uopValid,
    input  logic [WIDTH_UOPS*SQN_W-1:0]   IN_uopSqN,
    input  logic [WIDTH_UOPS*TAG_W-1:0]   IN_uopTagDst,
    input  logic [WIDTH_UOPS*NM_W-1:0]    IN_uopNmDst,
    input  logic [WIDTH_UOPS-1:0]         IN_uopAvail,
    input  logic [WIDTH_UOPS-1:0]         IN_uopIsLoad,
    input  logic [WIDTH_UOPS-1:0]         IN_uopIsStore,
    input  logic [WIDTH_WR-1:0]           IN_wbValid,
    input  logic [WIDTH_WR*SQN_W-1:0]     IN_wbSqN,
    input  logic                          IN_branchTaken,
    input  logic [SQN_W-1:0]              IN_branchSqN,
    output logic [WIDTH_UOPS*COM_W-1:0]   OUT_comUOp,
    output logic [SQN_W-1:0]              OUT_curSqN,
    output logic [SQN_W-1:0]              OUT_maxSqN
);

    localparam int unsigned IDX_W = $clog2(LENGTH);
    localparam int unsigned CNT_W = $clog2(WIDTH_UOPS + 1);

    rob_entry_t                          r_ent     [LENGTH];
    rob_entry_t                          w_ent_nxt [LENGTH];
    logic [SQN_W-1:0]                    r_head;
    logic [SQN_W-1:0]                    r_max_sqn;
    logic [SQN_W-1:0]                    w_head_nxt;
    logic [WIDTH_UOPS*COM_W-1:0]         r_com_uop;
    logic [WIDTH_UOPS*COM_W-1:0]         w_com_nxt;

    logic [WIDTH_UOPS-1:0][IDX_W-1:0]    w_hd_idx;
    logic [WIDTH_UOPS-1:0]               w_hd_valid;
    logic [WIDTH_UOPS-1:0]               w_hd_done;
    logic [WIDTH_UOPS-1:0][SQN_W-1:0]    w_hd_sqn;
    logic [WIDTH_UOPS-1:0]               w_mask;
    logic [CNT_W-1:0]                    w_count;

    // Gather the head window for the commit scan.
    always_comb begin
        w_hd_idx   = '0;
        w_hd_valid = '0;
        w_hd_done  = '0;
        w_hd_sqn   = '0;
        for (int s = 0; s < int'(WIDTH_UOPS); s++) begin
            w_hd_idx[s]   = IDX_W'(r_head + SQN_W'(s));
            w_hd_valid[s] = r_ent[w_hd_idx[s]].valid;
            w_hd_done[s]  = r_ent[w_hd_idx[s]].done;
            w_hd_sqn[s]   = r_ent[w_hd_idx[s]].sqn;
        end
    end

    rob_commit_select #(
        .WIDTH (WIDTH_UOPS),
        .CNT_W (CNT_W)
    ) u_commit_select (
        .i_valid        (w_hd_valid),
        .i_done         (w_hd_done),
        .i_sqn          (w_hd_sqn),
        .i_branch_taken (IN_branchTaken),
        .i_branch_sqn   (IN_branchSqN),
        .o_mask_c       (w_mask),
        .o_count_c      (w_count)
    );

    // Entry update order: retire, squash, writeback, then issue.
    always_comb begin
        logic [SQN_W-1:0] wb_sqn;
        logic [SQN_W-1:0] iss_sqn;
        logic [IDX_W-1:0] idx;
        logic             wb_hit;

        wb_sqn  = '0;
        iss_sqn = '0;
        idx     = '0;
        wb_hit  = 1'b0;

        for (int e = 0; e < int'(LENGTH); e++) begin
            w_ent_nxt[e] = r_ent[e];
        end

        for (int s = 0; s < int'(WIDTH_UOPS); s++) begin
            if (w_mask[s]) begin
                w_ent_nxt[w_hd_idx[s]].valid = 1'b0;
            end
        end

        if (IN_branchTaken) begin
            for (int e = 0; e < int'(LENGTH); e++) begin
                if (r_ent[e].valid && sqn_younger(r_ent[e].sqn, IN_branchSqN)) begin
                    w_ent_nxt[e].valid = 1'b0;
                end
            end
        end

        for (int k = 0; k < int'(WIDTH_WR); k++) begin
            wb_sqn = IN_wbSqN[k*SQN_W +: SQN_W];
            idx    = IDX_W'(wb_sqn);
            if (IN_wbValid[k] && r_ent[idx].valid && (r_ent[idx].sqn == wb_sqn)) begin
                w_ent_nxt[idx].done = 1'b1;
            end
        end

        if (!IN_branchTaken) begin
            for (int i = 0; i < int'(WIDTH_UOPS); i++) begin
                iss_sqn = IN_uopSqN[i*SQN_W +: SQN_W];
                idx     = IDX_W'(iss_sqn);
                // A writeback racing the issue of the same sqN still marks it done.
                wb_hit  = 1'b0;
                for (int k = 0; k < int'(WIDTH_WR); k++) begin
                    if (IN_wbValid[k] && (IN_wbSqN[k*SQN_W +: SQN_W] == iss_sqn)) begin
                        wb_hit = 1'b1;
                    end
                end
                if (IN_uopValid[i]) begin
                    w_ent_nxt[idx].valid    = 1'b1;
                    w_ent_nxt[idx].done     = IN_uopAvail[i] | wb_hit;
                    w_ent_nxt[idx].sqn      = iss_sqn;
                    w_ent_nxt[idx].tag_dst  = IN_uopTagDst[i*TAG_W +: TAG_W];
                    w_ent_nxt[idx].nm_dst   = IN_uopNmDst[i*NM_W +: NM_W];
                    w_ent_nxt[idx].avail    = IN_uopAvail[i];
                    w_ent_nxt[idx].is_load  = IN_uopIsLoad[i];
                    w_ent_nxt[idx].is_store = IN_uopIsStore[i];
                end
            end
        end
    end

    // Commit bundles in program order; non-committed slots stay all-zero.
    always_comb begin
        w_com_nxt = '0;
        for (int s = 0; s < int'(WIDTH_UOPS); s++) begin
            if (w_mask[s]) begin
                w_com_nxt[s*COM_W + COM_VALID_BIT]         = 1'b1;
                w_com_nxt[s*COM_W + COM_AVAIL_BIT]         = r_ent[w_hd_idx[s]].avail;
                w_com_nxt[s*COM_W + COM_LOAD_BIT]          = r_ent[w_hd_idx[s]].is_load;
                w_com_nxt[s*COM_W + COM_STORE_BIT]         = r_ent[w_hd_idx[s]].is_store;
                w_com_nxt[s*COM_W + COM_SQN_LSB +: SQN_W]  = r_ent[w_hd_idx[s]].sqn;
                w_com_nxt[s*COM_W + COM_TAG_LSB +: TAG_W]  = r_ent[w_hd_idx[s]].tag_dst;
                w_com_nxt[s*COM_W + COM_NM_LSB  +: NM_W]   = r_ent[w_hd_idx[s]].nm_dst;
            end
        end
    end

    assign w_head_nxt = r_head + SQN_W'(w_count);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < int'(LENGTH); e++) begin
                r_ent[e] <= '0;
            end
            r_head    <= '0;
            r_max_sqn <= SQN_W'(LENGTH - 1);
            r_com_uop <= '0;
        end else begin
            for (int e = 0; e < int'(LENGTH); e++) begin
                r_ent[e] <= w_ent_nxt[e];
            end
            r_head    <= w_head_nxt;
            r_max_sqn <= w_head_nxt + SQN_W'(LENGTH - 1);
            r_com_uop <= w_com_nxt;
        end
    end

    assign OUT_comUOp = r_com_uop;
    assign OUT_curSqN = r_head;
    assign OUT_maxSqN = r_max_sqn;

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: directed issue/writeback/branch vectors push expected
// commit bundles; a negedge monitor pops and compares every committed slot.
module tb_reorder_buffer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   IN_uopValid   = '0;
    logic [27:0]  IN_uopSqN     = '0;
    logic [27:0]  IN_uopTagDst  = '0;
    logic [19:0]  IN_uopNmDst   = '0;
    logic [3:0]   IN_uopAvail   = '0;
    logic [3:0]   IN_uopIsLoad  = '0;
    logic [3:0]   IN_uopIsStore = '0;
    logic [3:0]   IN_wbValid    = '0;
    logic [27:0]  IN_wbSqN      = '0;
    logic         IN_branchTaken = 1'b0;
    logic [6:0]   IN_branchSqN  = '0;
    logic [91:0]  OUT_comUOp;
    logic [6:0]   OUT_curSqN;
    logic [6:0]   OUT_maxSqN;

    int           checks   = 0;
    int           failures = 0;
    bit           started  = 1'b0;
    logic [22:0]  tb_ent [128];
    logic [22:0]  sb_q [$];

    reorder_buffer dut (
        .clk            (clk),
        .rst            (rst),
        .IN_uopValid    (IN_uopValid),
        .IN_uopSqN      (IN_uopSqN),
        .IN_uopTagDst   (IN_uopTagDst),
        .IN_uopNmDst    (IN_uopNmDst),
        .IN_uopAvail    (IN_uopAvail),
        .IN_uopIsLoad   (IN_uopIsLoad),
        .IN_uopIsStore  (IN_uopIsStore),
        .IN_wbValid     (IN_wbValid),
        .IN_wbSqN       (IN_wbSqN),
        .IN_branchTaken (IN_branchTaken),
        .IN_branchSqN   (IN_branchSqN),
        .OUT_comUOp     (OUT_comUOp),
        .OUT_curSqN     (OUT_curSqN),
        .OUT_maxSqN     (OUT_maxSqN)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        IN_uopValid    = '0;
        IN_uopSqN      = '0;
        IN_uopTagDst   = '0;
        IN_uopNmDst    = '0;
        IN_uopAvail    = '0;
        IN_uopIsLoad   = '0;
        IN_uopIsStore  = '0;
        IN_wbValid     = '0;
        IN_wbSqN       = '0;
        IN_branchTaken = 1'b0;
        IN_branchSqN   = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        started = 1'b1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // Drive one issue slot and record the bundle it should eventually retire as.
    task automatic set_slot(input int s, input int sqn, input int nm, input int tag,
                            input bit av, input bit ld, input bit st);
        logic [6:0] q;
        logic [6:0] d;
        q = 7'(sqn);
        d = q - OUT_curSqN;
        assert (d < 7'd64) else $error("issue sqN %0d overruns window at head %0d", q, OUT_curSqN);
        IN_uopValid[s]          = 1'b1;
        IN_uopSqN[s*7 +: 7]     = q;
        IN_uopTagDst[s*7 +: 7]  = 7'(tag);
        IN_uopNmDst[s*5 +: 5]   = 5'(nm);
        IN_uopAvail[s]          = av;
        IN_uopIsLoad[s]         = ld;
        IN_uopIsStore[s]        = st;
        tb_ent[q] = {5'(nm), 7'(tag), q, st, ld, av, 1'b1};
    endtask

    task automatic set_wb(input int k, input int sqn);
        IN_wbValid[k]       = 1'b1;
        IN_wbSqN[k*7 +: 7]  = 7'(sqn);
    endtask

    task automatic expect_commit(input int sqn);
        sb_q.push_back(tb_ent[7'(sqn)]);
    endtask

    // Monitor: committed slots must form a prefix and match the scoreboard in order.
    always @(negedge clk) begin
        logic        gap;
        logic [22:0] got;
        logic [22:0] exp;
        gap = 1'b0;
        for (int s = 0; s < 4; s++) begin
            got = OUT_comUOp[s*23 +: 23];
            if (got[0] === 1'b1) begin
                checks++;
                if (gap) begin
                    failures++;
                    $display("FAIL com_gap slot=%0d got=%h expected no commit after empty slot", s, got);
                end else if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL com_unexpected slot=%0d got=%h expected none", s, got);
                end else begin
                    exp = sb_q.pop_front();
                    if (got !== exp) begin
                        failures++;
                        $display("FAIL com_bundle slot=%0d got=%h expected=%h", s, got, exp);
                    end
                end
            end else begin
                gap = 1'b1;
                if (started) begin
                    checks++;
                    if (got !== 23'd0) begin
                        failures++;
                        $display("FAIL com_idle_zero slot=%0d got=%h expected=0", s, got);
                    end
                end
            end
        end
    end

    initial begin
        // Reset state
        do_reset();
        check("rst_cur", int'(OUT_curSqN), 0);
        check("rst_max", int'(OUT_maxSqN), 63);
        check("rst_com_zero", int'(OUT_comUOp !== '0), 0);

        // Single retire: all four complete together, commit two edges after writeback
        for (int s = 0; s < 4; s++) set_slot(s, s, s + 1, s + 5, 1'b0, 1'b0, 1'b0);
        tick();
        idle(1);
        for (int s = 0; s < 4; s++) begin
            set_wb(s, s);
            expect_commit(s);
        end
        tick();
        check("single_cur_early", int'(OUT_curSqN), 0);
        tick();
        check("single_cur", int'(OUT_curSqN), 4);
        check("single_max", int'(OUT_maxSqN), 67);
        idle(2);

        // Hole: sqN 2 blocks 3 until its own writeback
        do_reset();
        set_slot(0, 0, 1, 10, 1'b0, 1'b0, 1'b0);
        set_slot(1, 1, 2, 11, 1'b0, 1'b1, 1'b0);
        set_slot(2, 2, 3, 12, 1'b0, 1'b0, 1'b1);
        set_slot(3, 3, 4, 13, 1'b0, 1'b1, 1'b0);
        tick();
        set_wb(0, 0);
        set_wb(1, 1);
        set_wb(3, 3);
        expect_commit(0);
        expect_commit(1);
        tick();
        tick();
        check("hole_cur_part", int'(OUT_curSqN), 2);
        check("hole_max_part", int'(OUT_maxSqN), 65);
        idle(3);
        check("hole_cur_blocked", int'(OUT_curSqN), 2);
        set_wb(2, 2);
        expect_commit(2);
        expect_commit(3);
        tick();
        tick();
        check("hole_cur_done", int'(OUT_curSqN), 4);
        check("hole_max_done", int'(OUT_maxSqN), 67);
        idle(2);

        // Mispredict: squash 4..7, ignore a same-cycle issue of sqN 8
        do_reset();
        for (int s = 0; s < 4; s++) set_slot(s, s, s + 1, 20 + s, s != 0, 1'b0, 1'b0);
        tick();
        for (int s = 0; s < 4; s++) set_slot(s, 4 + s, 9, 30 + s, 1'b1, 1'b0, 1'b0);
        tick();
        IN_branchTaken = 1'b1;
        IN_branchSqN   = 7'd3;
        set_slot(0, 8, 7, 99, 1'b1, 1'b0, 1'b0);
        tick();
        set_wb(0, 0);
        for (int s = 0; s < 4; s++) expect_commit(s);
        tick();
        tick();
        check("mp_cur", int'(OUT_curSqN), 4);
        idle(3);
        check("mp_cur_squashed", int'(OUT_curSqN), 4);
        check("mp_max", int'(OUT_maxSqN), 67);
        for (int s = 0; s < 4; s++) begin
            set_slot(s, 4 + s, 12 + s, 40 + s, 1'b1, 1'b0, 1'b1);
            expect_commit(4 + s);
        end
        tick();
        tick();
        idle(3);
        check("mp_cur_reissue", int'(OUT_curSqN), 8);

        // Branch gating: done entries younger than the branch do not commit
        do_reset();
        for (int s = 0; s < 4; s++) set_slot(s, s, 2 + s, 50 + s, 1'b1, 1'b0, 1'b0);
        tick();
        IN_branchTaken = 1'b1;
        IN_branchSqN   = 7'd1;
        expect_commit(0);
        expect_commit(1);
        tick();
        check("gate_cur", int'(OUT_curSqN), 2);
        idle(3);
        check("gate_cur_hold", int'(OUT_curSqN), 2);

        // Same cycle: writeback of sqN 2 with branch at 1 -> 0,1 commit, 2 squashed
        do_reset();
        for (int s = 0; s < 3; s++) set_slot(s, s, 6 + s, 60 + s, 1'b0, 1'b0, 1'b0);
        tick();
        set_wb(0, 0);
        set_wb(1, 1);
        tick();
        set_wb(2, 2);
        IN_branchTaken = 1'b1;
        IN_branchSqN   = 7'd1;
        expect_commit(0);
        expect_commit(1);
        tick();
        check("same_cur", int'(OUT_curSqN), 2);
        idle(3);
        check("same_cur_hold", int'(OUT_curSqN), 2);

        // Reset mid-operation: pending commits are discarded
        do_reset();
        for (int s = 0; s < 4; s++) set_slot(s, s, 1, 70 + s, 1'b1, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_com_zero", int'(OUT_comUOp !== '0), 0);
        check("midrst_cur", int'(OUT_curSqN), 0);
        check("midrst_max", int'(OUT_maxSqN), 63);
        idle(3);
        check("midrst_cur_hold", int'(OUT_curSqN), 0);

        // Wrap: sqN 0..131 streamed four per cycle, all born done
        for (int b = 0; b < 33; b++) begin
            for (int s = 0; s < 4; s++) begin
                set_slot(s, 4 * b + s, (4 * b + s) % 32, ((4 * b + s) * 3) % 128,
                         1'b1, ((4 * b + s) % 5) == 0, ((4 * b + s) % 7) == 0);
                expect_commit(4 * b + s);
            end
            tick();
            if (b == 17) begin
                check("wrap_cur_68", int'(OUT_curSqN), 68);
                check("wrap_max_3", int'(OUT_maxSqN), 3);
            end
        end
        idle(3);
        check("wrap_cur_end", int'(OUT_curSqN), 4);
        check("wrap_max_end", int'(OUT_maxSqN), 67);

        // Drain with a bounded wait, then every expected commit must have been seen
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
        check("scoreboard_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
